// File: rtl/des_pkg.sv
// Shared DES S-box definitions: field widths, the inverse-lookup FSM states and
// helpers for moving between a 6-bit S-box address and its row/column fields.
package des_pkg;

    localparam int SBOX_IN_W  = 6;
    localparam int SBOX_OUT_W = 4;
    localparam int ROW_W      = 2;
    localparam int COL_W      = 4;
    localparam int TBL_DEPTH  = 1 << SBOX_IN_W;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    // The DES row selector lives in the outer address bits, the column in the middle.
    function automatic logic [SBOX_IN_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                       input logic [COL_W-1:0] col);
        return {row[1], col, row[0]};
    endfunction

    function automatic logic [ROW_W-1:0] addr_row(input logic [SBOX_IN_W-1:0] a);
        return {a[5], a[0]};
    endfunction

    function automatic logic [COL_W-1:0] addr_col(input logic [SBOX_IN_W-1:0] a);
        return a[4:1];
    endfunction

endpackage

// File: rtl/s6_inv_lookup_sbox.sv
// Forward DES S-box 6: purely combinational 6-bit address to 4-bit output.
import des_pkg::*;

module s6_inv_lookup_sbox (
    input  logic [SBOX_IN_W-1:0]  addr,
    output logic [SBOX_OUT_W-1:0] sout
);

    localparam logic [SBOX_OUT_W-1:0] S6 [4][16] = '{
        '{4'd12, 4'd1,  4'd10, 4'd15, 4'd9,  4'd2,  4'd6,  4'd8,  4'd0,  4'd13, 4'd3,  4'd4,  4'd14, 4'd7,  4'd5,  4'd11},
        '{4'd10, 4'd15, 4'd4,  4'd2,  4'd7,  4'd12, 4'd9,  4'd5,  4'd6,  4'd1,  4'd13, 4'd14, 4'd0,  4'd11, 4'd3,  4'd8},
        '{4'd9,  4'd14, 4'd15, 4'd5,  4'd2,  4'd8,  4'd12, 4'd3,  4'd7,  4'd0,  4'd4,  4'd10, 4'd1,  4'd13, 4'd11, 4'd6},
        '{4'd4,  4'd3,  4'd2,  4'd12, 4'd9,  4'd5,  4'd15, 4'd10, 4'd11, 4'd14, 4'd1,  4'd7,  4'd6,  4'd0,  4'd8,  4'd13}
    };

    assign sout = S6[addr_row(addr)][addr_col(addr)];

endmodule

// File: rtl/s6_inv_lookup.sv
// Inverse S-box 6 lookup: after reset, sweeps the forward S-box to build a
// (row, output) -> column table with a permutation self-check, then serves queries.
import des_pkg::*;

module s6_inv_lookup (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROW_W-1:0]      in_row,
    input  logic [SBOX_OUT_W-1:0] in_sout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SBOX_IN_W-1:0]  out_address,
    output logic                  init_busy,
    output logic                  init_err
);

    state_t                 state_q, state_d;
    logic [SBOX_IN_W-1:0]   idx_q;
    logic [SBOX_OUT_W-1:0]  fwd_sout;
    logic [COL_W-1:0]       inv [TBL_DEPTH];
    logic [TBL_DEPTH-1:0]   bitmap_q, bitmap_nxt;
    logic [SBOX_IN_W-1:0]   wr_key;
    logic                   init_last;
    logic                   accept;

    s6_inv_lookup_sbox u_fwd (
        .addr (idx_q),
        .sout (fwd_sout)
    );

    // Inverse table is keyed the same way queries arrive: {row, sbox output}.
    assign wr_key     = {addr_row(idx_q), fwd_sout};
    assign init_last  = (idx_q == SBOX_IN_W'(TBL_DEPTH - 1));
    assign bitmap_nxt = bitmap_q | (TBL_DEPTH'(1) << wr_key);
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_last) state_d = ST_SERVE;
    end

    always_comb begin
        init_busy = rst || (state_q == ST_INIT);
        in_ready  = !rst && (state_q == ST_SERVE) && (!out_valid || out_ready);
    end

    // Build bookkeeping; the coverage check folds in the final write so a
    // missing entry is flagged on the same edge that enters SERVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            bitmap_q <= '0;
            init_err <= 1'b0;
        end else if (state_q == ST_INIT) begin
            bitmap_q <= bitmap_nxt;
            if (bitmap_q[wr_key])              init_err <= 1'b1;
            if (init_last && !(&bitmap_nxt))   init_err <= 1'b1;
            if (!init_last)                    idx_q    <= idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_INIT) inv[wr_key] <= addr_col(idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_address <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_address <= pack_addr(in_row, inv[{in_row, in_sout}]);
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_s6_inv_lookup.sv
// Self-checking bench for s6_inv_lookup: transaction-level model built from the
// DES S6 table, randomized and directed queries, backpressure, reset and fault cases.
module tb_s6_inv_lookup;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_row;
    logic [3:0] in_sout;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_address;
    logic       init_busy;
    logic       init_err;

    int n_chk = 0;
    int n_err = 0;

    bit m_valid = 1'b0;
    int m_addr  = 0;

    int s6 [4][16] = '{
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11},
        '{10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8},
        '{9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6},
        '{4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13}
    };

    s6_inv_lookup dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row      (in_row),
        .in_sout     (in_sout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_address (out_address),
        .init_busy   (init_busy),
        .init_err    (init_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference inverse: search the row for the column holding s.
    function automatic int ref_addr(input int row, input int s);
        for (int c = 0; c < 16; c++)
            if (s6[row][c] == s) return ((row >> 1) << 5) | (c << 1) | (row & 1);
        return -1;
    endfunction

    // One cycle: drive at negedge, check in_ready, advance model at posedge, check outputs.
    task automatic step(input bit v, input int row, input int s, input bit ordy);
        bit acc;
        in_valid  = v;
        in_row    = row[1:0];
        in_sout   = s[3:0];
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, 32'(!m_valid || ordy));
        acc = v && (!m_valid || ordy);
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            m_addr  = ref_addr(row, s);
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        chk("out_valid", out_valid, 32'(m_valid));
        if (m_valid) chk("out_address", out_address, m_addr);
    endtask

    // Pulse reset for one edge, then watch the build phase; optionally corrupt
    // the forward output for the first four sweep entries.
    task automatic do_reset(input bit fault);
        int cnt;
        int bad_rdy;
        rst = 1'b1;
        #1;
        chk("rst_busy", init_busy, 1);
        chk("rst_rdy", in_ready, 0);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_address, 0);
        chk("rst_err", init_err, 0);
        rst     = 1'b0;
        m_valid = 1'b0;
        cnt     = 0;
        bad_rdy = 0;
        out_ready = 1'b1;
        while (init_busy && cnt < 200) begin
            if (fault && cnt == 0) force dut.fwd_sout = 4'd12;
            if (fault && cnt == 4) release dut.fwd_sout;
            in_valid = 1'($urandom_range(0, 1));
            in_row   = 2'($urandom);
            in_sout  = 4'($urandom);
            #1;
            if (in_ready) bad_rdy++;
            @(negedge clk);
            cnt++;
        end
        in_valid = 1'b0;
        #1;
        chk("init_len", cnt, 64);
        chk("init_rdy_low", bad_rdy, 0);
        chk("init_done_rdy", in_ready, 1);
        chk("init_done_valid", out_valid, 0);
        chk("init_err", init_err, 32'(fault));
    endtask

    int c_row [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int c_s   [8] = '{12, 10, 9, 13, 11, 0, 0, 4};
    int c_exp [8] = '{'h00, 'h01, 'h20, 'h3F, 'h1E, 'h19, 'h32, 'h21};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_row = '0; in_sout = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        do_reset(1'b0);

        for (int i = 0; i < 8; i++) begin
            step(1'b1, c_row[i], c_s[i], 1'b1);
            chk("corner", out_address, c_exp[i]);
        end

        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 16; s++) begin
                step(1'b1, r, s, 1'b1);
                chk("sweep_fwd", s6[{out_address[5], out_address[0]}][out_address[4:1]], s);
                chk("sweep_row", {out_address[5], out_address[0]}, r);
            end

        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 3, 4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'b0);
            chk("bp_addr", out_address, 'h21);
            chk("bp_rdy", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", in_ready, 1);
        step(1'b0, 0, 0, 1'b1);

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));

        step(1'b1, 1, 0, 1'b0);
        chk("pre_rst_valid", out_valid, 1);
        do_reset(1'b0);
        for (int i = 0; i < 40; i++)
            step(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'b1);

        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, 0, 1'b1);
            chk("err_sticky", init_err, 1);
        end
        do_reset(1'b0);
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/s6_inv_lookup.md
# s6_inv_lookup

Inverse lookup for DES S-box 6: given a row selector and a 4-bit S-box output, returns the unique 6-bit S-box address that produces it. Each S6 row is a permutation of 0..15, so the inverse is exact. After reset the block builds its 64-entry inverse table by sweeping the existing forward S6 lookup, with a self-check. It then serves valid/ready queries with one-cycle latency. It sits beside the DES datapath for key-recovery, analysis and self-test tooling.

## Interface
- No parameters; table depth 64 and widths are fixed by DES.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  query present
- in_ready  out  1  block accepts query this cycle
- in_row  in  2  S-box row, {address[5], address[0]}
- in_sout  in  4  S-box output value to invert
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_address  out  6  recovered address {row[1], col[3:0], row[0]}
- init_busy  out  1  table build in progress
- init_err  out  1  sticky: table self-check failed

## Operation
- FSM states: INIT, SERVE.
- Reset forces INIT, idx=0, the written bitmap clear, init_err=0, out_valid=0 and out_address=0. While rst is high, init_busy=1 and in_ready=0.
- INIT:
  - Each cycle, drive the forward lookup with address idx (6-bit counter).
  - With row={idx[5],idx[0]}, col=idx[4:1] and s=forward output, write inv[{row,s}] <= col.
  - If bitmap[{row,s}] is already set, set init_err (duplicate). Otherwise set the bitmap bit.
  - At idx=63, do the final write, then go to SERVE. The counter does not wrap back into INIT.
- SERVE:
  - On entry, if any bitmap bit is clear, set init_err.
  - init_busy=0.
  - in_ready = !out_valid || out_ready.
  - When a query is accepted (in_valid && in_ready), next cycle out_address = {in_row[1], inv[{in_row,in_sout}], in_row[0]} and out_valid=1.
  - When out_valid && out_ready and no new accept, out_valid falls.
  - Simultaneous accept and drain replaces the result with no bubble.
- Queries are ignored during INIT because in_ready=0. in_valid is don't-care in INIT.
- init_err does not block SERVE. Results are still produced, and the consumer must gate on init_err.
- The table is 64×4 flops (or inferred RAM with synchronous write and asynchronous read). Its contents are undefined before INIT writes them.

## Timing
- INIT lasts exactly 64 cycles after the first clk edge with rst low. in_ready first rises in cycle 64, counting that edge as cycle 0.
- Query latency is 1 cycle, from accept edge to out_valid.
- Throughput is 1 query/cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, out_address is held stable and in_ready=0.
- rst mid-INIT or mid-SERVE: on the next edge, out_valid=0 and any pending result is dropped. The full INIT restarts from idx=0, and the bitmap and init_err clear.

## Structure
- Shared package `des_pkg`:
  - Widths: SBOX_IN_W=6, SBOX_OUT_W=4, ROW_W=2.
  - FSM state enum.
  - Address pack/unpack helpers: row/col to address and back.
- One sub-module: the existing forward S6 lookup, instantiated for the INIT sweep. Do not duplicate its table here.
- Top-level contents: FSM, idx counter, inverse table, bitmap, output register.

## Test plan
- Reset release: init_busy=1 and in_ready=0 for 64 cycles, then init_busy=0, in_ready=1, init_err=0.
- Corner queries, out_ready=1, back-to-back:
  - (row0, 12) -> 0x00
  - (row1, 10) -> 0x01
  - (row2, 9) -> 0x20
  - (row3, 13) -> 0x3F
  - (row0, 11) -> 0x1E
  - Each result arrives one cycle after accept.
- Mid-table queries: (row1, 0) -> 0x19 and (row2, 0) -> 0x32. Also run an exhaustive 64-query sweep in which forward(out_address) == in_sout and the out_address row bits match in_row.
- Backpressure: hold out_ready=0 for 5 cycles after query (row3, 4) -> 0x21. Require out_address stable at 0x21, in_ready=0, no second accept. Then release: one result, and in_ready=1 in the same cycle.
- Reset during SERVE with out_valid=1: out_valid=0 on the next edge, a full 64-cycle INIT repeats, and subsequent queries are correct.
- Fault injection by force on the forward output during INIT (duplicate value in row 0): init_err=1 by end of INIT, stays set in SERVE, and clears only on rst.
